// File: rtl/data_bus_responder.sv
// ----------------------------------------------------------------------------
// data_bus_responder
//
// Responder side of the CPU data-memory port. Each access is decoded to one of
// three targets:
//   - on-chip data RAM (byte-writable, asynchronous read, not reset)
//   - console-output FIFO, drained over a cons_data/cons_valid/cons_ready stream
//   - free-running 32-bit cycle counter
// Register window at IO_BASE:
//   +0x0 CONS_DATA   (W: push byte [7:0] when byte_enable[0]; R: 0)
//   +0x4 CONS_STATUS (R: {29'b0, overflow, full, empty}; W: bit 2 clears overflow)
//   +0x8 CYCLE       (R: counter; W: byte-merge into counter)
//   +0xC CONS_COUNT  (R: entries held; W: ignored)
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   memory_address      byte address; bits [1:0] ignored
//   memory_write        write data
//   memory_byte_enable  per-byte write enable
//   memory_we           write strobe
//   memory_read         combinational read data for memory_address
//   cons_data           byte at the FIFO head
//   cons_valid          FIFO not empty
//   cons_ready          sink accepts head byte when cons_valid is high
//   bad_access          memory_we high on an unmapped address (no side effects)
// ----------------------------------------------------------------------------
module data_bus_responder #(
    parameter int          RAM_WORDS  = 1024,
    parameter int          FIFO_DEPTH = 8,
    parameter logic [31:0] IO_BASE    = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] memory_address,
    input  logic [31:0] memory_write,
    input  logic [3:0]  memory_byte_enable,
    input  logic        memory_we,
    output logic [31:0] memory_read,
    output logic [7:0]  cons_data,
    output logic        cons_valid,
    input  logic        cons_ready,
    output logic        bad_access
);

    localparam int AW = $clog2(RAM_WORDS);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic          ram_sel;
    logic          io_win;
    logic          sel_cdata;
    logic          sel_status;
    logic          sel_cycle;
    logic          sel_count;
    logic [AW-1:0] ram_idx;

    // RAM occupies the bottom RAM_WORDS*4 bytes: every bit above the word
    // index must be zero.
    assign ram_sel    = (memory_address[31:AW+2] == '0);
    // The register window is 16 bytes; IO_BASE is expected 16-byte aligned.
    assign io_win     = (memory_address[31:4] == IO_BASE[31:4]);
    assign sel_cdata  = io_win && (memory_address[3:2] == 2'd0);
    assign sel_status = io_win && (memory_address[3:2] == 2'd1);
    assign sel_cycle  = io_win && (memory_address[3:2] == 2'd2);
    assign sel_count  = io_win && (memory_address[3:2] == 2'd3);
    assign ram_idx    = memory_address[AW+1:2];

    assign bad_access = memory_we && !(ram_sel || io_win);

    // Byte-lane offset is irrelevant for word accesses.
    logic unused_addr_lsb;
    assign unused_addr_lsb = ^memory_address[1:0];

    // ------------------------------------------------------------------
    // Data RAM: no reset, so a write coinciding with rst still commits.
    // ------------------------------------------------------------------
    logic [31:0] ram [RAM_WORDS];

    always_ff @(posedge clk) begin
        if (memory_we && ram_sel) begin
            for (int i = 0; i < 4; i++) begin
                if (memory_byte_enable[i])
                    ram[ram_idx][8*i +: 8] <= memory_write[8*i +: 8];
            end
        end
    end

    // ------------------------------------------------------------------
    // Console FIFO
    // ------------------------------------------------------------------
    logic [7:0]    fifo_mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          overflow;

    logic fifo_empty;
    logic fifo_full;
    logic pop;
    logic push_req;
    logic push;
    logic ovf_set;
    logic ovf_clr;

    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == FULL_CNT);
    assign pop        = !fifo_empty && cons_ready;
    assign push_req   = memory_we && sel_cdata && memory_byte_enable[0];
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign push       = push_req && (!fifo_full || pop);
    assign ovf_set    = push_req && fifo_full && !pop;
    assign ovf_clr    = memory_we && sel_status && memory_byte_enable[0] &&
                        memory_write[2];

    // Storage itself needs no reset; only pointers/count define occupancy.
    always_ff @(posedge clk) begin
        if (push && !rst)
            fifo_mem[wr_ptr] <= memory_write[7:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            // Power-of-two depth: pointer wrap is the natural rollover.
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            // Set has priority over a same-cycle clear.
            overflow <= ovf_set || (overflow && !ovf_clr);
        end
    end

    // No bypass: the head is always a registered entry.
    assign cons_data  = fifo_mem[rd_ptr];
    assign cons_valid = !fifo_empty;

    // ------------------------------------------------------------------
    // Cycle counter
    // ------------------------------------------------------------------
    logic [31:0] cycle_cnt;
    logic [31:0] cycle_merged;
    logic        cycle_wr;

    // A write with no enabled bytes leaves the counter running.
    assign cycle_wr = memory_we && sel_cycle && (memory_byte_enable != 4'b0000);

    always_comb begin
        cycle_merged = cycle_cnt;
        for (int i = 0; i < 4; i++) begin
            if (memory_byte_enable[i])
                cycle_merged[8*i +: 8] = memory_write[8*i +: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            cycle_cnt <= '0;
        else if (cycle_wr)
            cycle_cnt <= cycle_merged;
        else
            cycle_cnt <= cycle_cnt + 32'd1;
    end

    // ------------------------------------------------------------------
    // Read mux (zero latency; byte enables ignored)
    // ------------------------------------------------------------------
    always_comb begin
        memory_read = '0;
        if (ram_sel)
            memory_read = ram[ram_idx];
        else if (sel_status)
            memory_read = {29'b0, overflow, fifo_full, fifo_empty};
        else if (sel_cycle)
            memory_read = cycle_cnt;
        else if (sel_count)
            memory_read = {{(32-CW){1'b0}}, count};
    end

endmodule

// File: tb/tb_data_bus_responder.sv
module tb_data_bus_responder;

    localparam int          RW  = 1024;
    localparam int          FD  = 8;
    localparam logic [31:0] IOB = 32'h8000_0000;

    logic        clk;
    logic        rst;
    logic [31:0] memory_address;
    logic [31:0] memory_write;
    logic [3:0]  memory_byte_enable;
    logic        memory_we;
    logic [31:0] memory_read;
    logic [7:0]  cons_data;
    logic        cons_valid;
    logic        cons_ready;
    logic        bad_access;

    data_bus_responder #(.RAM_WORDS(RW), .FIFO_DEPTH(FD), .IO_BASE(IOB)) dut (
        .clk(clk), .rst(rst),
        .memory_address(memory_address), .memory_write(memory_write),
        .memory_byte_enable(memory_byte_enable), .memory_we(memory_we),
        .memory_read(memory_read), .cons_data(cons_data),
        .cons_valid(cons_valid), .cons_ready(cons_ready),
        .bad_access(bad_access)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model state
    logic [31:0] ram_m   [RW];
    bit          known_m [RW];
    logic [7:0]  q [$];
    logic        ovf_m;
    logic [31:0] cyc_m;

    // Values observed in the most recent cycle
    logic [31:0] obs_rd;
    logic [7:0]  obs_cd;
    logic        obs_cv;
    logic        obs_bad;

    function automatic logic is_ram(input logic [31:0] a);
        return (a & ~32'd3) < 32'(RW * 4);
    endfunction

    function automatic logic is_mapped(input logic [31:0] a);
        logic [31:0] w;
        w = a & ~32'd3;
        return is_ram(a) || (w >= IOB && w < IOB + 32'd16);
    endfunction

    function automatic logic [31:0] exp_read(input logic [31:0] a);
        logic [31:0] w;
        w = a & ~32'd3;
        if (is_ram(a))          return ram_m[w[11:2]];
        if (w == IOB + 32'd4)   return {29'b0, ovf_m, q.size() == FD, q.size() == 0};
        if (w == IOB + 32'd8)   return cyc_m;
        if (w == IOB + 32'd12)  return 32'(q.size());
        return 32'd0;
    endfunction

    // One bus cycle: drive, check combinational outputs against the model,
    // advance the model by the access rules, then let the DUT clock.
    task automatic cyc(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be,
                       input logic we, input logic rdy, input logic r);
        logic [31:0] w;
        logic        full, popped, pushreq, clr, setf;
        w = a & ~32'd3;
        memory_address     = a;
        memory_write       = d;
        memory_byte_enable = be;
        memory_we          = we;
        cons_ready         = rdy;
        rst                = r;
        #1;
        obs_rd  = memory_read;
        obs_cd  = cons_data;
        obs_cv  = cons_valid;
        obs_bad = bad_access;
        if (!is_ram(a) || known_m[w[11:2]])
            chk("read", memory_read, exp_read(a));
        chk("bad_access", 32'(bad_access), 32'(we && !is_mapped(a)));
        chk("cons_valid", 32'(cons_valid), 32'(q.size() != 0));
        if (q.size() != 0)
            chk("cons_data", 32'(cons_data), 32'(q[0]));

        if (we && is_ram(a)) begin
            for (int i = 0; i < 4; i++)
                if (be[i]) ram_m[w[11:2]][8*i +: 8] = d[8*i +: 8];
            if (be == 4'hF) known_m[w[11:2]] = 1'b1;
        end
        if (r) begin
            q.delete();
            ovf_m = 1'b0;
            cyc_m = 32'd0;
        end else begin
            full    = (q.size() == FD);
            popped  = (q.size() != 0) && rdy;
            pushreq = we && (w == IOB) && be[0];
            clr     = we && (w == IOB + 32'd4) && be[0] && d[2];
            setf    = 1'b0;
            if (popped) void'(q.pop_front());
            if (pushreq) begin
                if (!full || popped) q.push_back(d[7:0]);
                else setf = 1'b1;
            end
            ovf_m = setf ? 1'b1 : (clr ? 1'b0 : ovf_m);
            if (we && (w == IOB + 32'd8) && be != 4'h0) begin
                for (int i = 0; i < 4; i++)
                    if (be[i]) cyc_m[8*i +: 8] = d[8*i +: 8];
            end else begin
                cyc_m = cyc_m + 32'd1;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic rd(input logic [31:0] a);
        cyc(a, 32'd0, 4'h0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0]  got_q [$];
        logic [7:0]  last;
        logic [31:0] a, d;

        memory_address = 0; memory_write = 0; memory_byte_enable = 0;
        memory_we = 0; cons_ready = 0; rst = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 0;
        ovf_m = 0; cyc_m = 0; q.delete();

        // Fill RAM with known contents
        for (int i = 0; i < RW; i++)
            cyc(32'(i * 4), $urandom, 4'hF, 1'b1, 1'b0, 1'b0);

        // Reset state
        cyc(IOB + 32'd4, 0, 0, 1'b0, 1'b0, 1'b1);
        rd(IOB + 32'd4);
        chk("rst_status", obs_rd, 32'h1);
        chk("rst_cvalid", 32'(obs_cv), 32'd0);

        // RAM byte lanes
        cyc(32'h10, 32'hAABBCCDD, 4'b1111, 1'b1, 1'b0, 1'b0);
        cyc(32'h10, 32'h11223344, 4'b0101, 1'b1, 1'b0, 1'b0);
        rd(32'h10);
        chk("ram_lanes", obs_rd, 32'hAA22CC44);
        rd(32'h12);
        chk("ram_lanes_off", obs_rd, 32'hAA22CC44);

        // FIFO stream
        for (int i = 0; i < 3; i++)
            cyc(IOB, 32'(8'h41 + i), 4'h1, 1'b1, 1'b0, 1'b0);
        rd(IOB + 32'd12);
        chk("stream_count", obs_rd, 32'd3);
        chk("stream_head", 32'(obs_cd), 32'h41);
        for (int i = 0; i < 3; i++) begin
            cyc(IOB + 32'd12, 0, 0, 1'b0, 1'b1, 1'b0);
            chk("stream_order", 32'(obs_cd), 32'(8'h41 + i));
        end
        rd(IOB + 32'd4);
        chk("stream_status", obs_rd, 32'h1);
        chk("stream_empty", 32'(obs_cv), 32'd0);

        // Overflow
        for (int i = 0; i < 9; i++)
            cyc(IOB, 32'(8'h50 + i), 4'h1, 1'b1, 1'b0, 1'b0);
        rd(IOB + 32'd4);
        chk("ovf_status", obs_rd, 32'h6);
        cyc(IOB + 32'd4, 32'h4, 4'h1, 1'b1, 1'b0, 1'b0);
        rd(IOB + 32'd4);
        chk("ovf_clear", obs_rd, 32'h2);
        cyc(IOB, 32'h99, 4'h1, 1'b1, 1'b1, 1'b0);
        rd(IOB + 32'd12);
        chk("full_push_pop_cnt", obs_rd, 32'd8);
        rd(IOB + 32'd4);
        chk("full_push_pop_st", obs_rd, 32'h2);
        last = 8'h00;
        for (int i = 0; i < 8; i++) begin
            cyc(IOB + 32'd12, 0, 0, 1'b0, 1'b1, 1'b0);
            last = obs_cd;
        end
        chk("ovf_tail", 32'(last), 32'h99);

        // Wrap-around: push on even cycles, pop on odd cycles
        got_q.delete();
        for (int c = 0; c < 40; c++) begin
            if (c % 2 == 0) begin
                cyc(IOB, 32'(c / 2), 4'h1, 1'b1, 1'b0, 1'b0);
            end else begin
                cyc(IOB + 32'd12, 0, 0, 1'b0, 1'b1, 1'b0);
                chk("wrap_cnt_le8", 32'(obs_rd <= 32'd8), 32'd1);
                if (obs_cv) got_q.push_back(obs_cd);
            end
        end
        for (int c = 0; c < 4; c++) begin
            cyc(IOB + 32'd12, 0, 0, 1'b0, 1'b1, 1'b0);
            if (obs_cv) got_q.push_back(obs_cd);
        end
        chk("wrap_total", 32'(got_q.size()), 32'd20);
        for (int j = 0; j < 20 && j < got_q.size(); j++)
            chk("wrap_order", 32'(got_q[j]), 32'(j));

        // CYCLE counter
        cyc(IOB + 32'd8, 0, 0, 1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 5; k++) begin
            rd(IOB + 32'd8);
            chk("cycle_k", obs_rd, 32'(k));
        end
        cyc(IOB + 32'd8, 32'hFFFF_FFFE, 4'hF, 1'b1, 1'b0, 1'b0);
        rd(IOB + 32'd8);
        chk("cycle_ld", obs_rd, 32'hFFFF_FFFE);
        rd(IOB + 32'd8);
        chk("cycle_max", obs_rd, 32'hFFFF_FFFF);
        rd(IOB + 32'd8);
        chk("cycle_wrap", obs_rd, 32'h0);

        // Unmapped write
        cyc(32'h4000_0000, 32'hDEAD_BEEF, 4'hF, 1'b1, 1'b0, 1'b0);
        chk("unmapped_bad", 32'(obs_bad), 32'd1);
        chk("unmapped_rd", obs_rd, 32'd0);
        rd(32'h10);
        chk("unmapped_ram", obs_rd, 32'hAA22CC44);

        // Reset with 3 bytes queued and overflow set, RAM write in same cycle
        for (int i = 0; i < 9; i++)
            cyc(IOB, 32'(8'h60 + i), 4'h1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++)
            cyc(IOB + 32'd12, 0, 0, 1'b0, 1'b1, 1'b0);
        cyc(32'h20, 32'h1234_5678, 4'hF, 1'b1, 1'b0, 1'b1);
        rd(IOB + 32'd8);
        chk("rst_cycle", obs_rd, 32'd0);
        chk("rst_cv", 32'(obs_cv), 32'd0);
        rd(IOB + 32'd4);
        chk("rst_status2", obs_rd, 32'h1);
        rd(32'h20);
        chk("rst_ram_wr", obs_rd, 32'h1234_5678);
        rd(32'h10);
        chk("rst_ram_keep", obs_rd, 32'hAA22CC44);

        // Randomized traffic against the model
        repeat (3000) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3: a = 32'($urandom_range(0, RW - 1)) << 2;
                4:          a = IOB;
                5:          a = IOB + 32'd4;
                6:          a = IOB + 32'd8;
                7:          a = IOB + 32'd12;
                8:          a = 32'h4000_0000 | ($urandom & 32'h0FFF_FFFC);
                default:    a = IOB + 32'd16 + (32'($urandom_range(0, 255)) << 2);
            endcase
            a = a | 32'($urandom_range(0, 3));
            d = $urandom;
            cyc(a, d, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), $urandom_range(0, 99) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/data_bus_responder.md
Name: data_bus_responder

Overview:
- Responder side of the CPU data-memory port. It receives memory_address, memory_write, memory_byte_enable and memory_we from the memory-access stage and returns memory_read.
- Decodes each access to one of three targets: an on-chip data RAM, a console-output FIFO drained over a valid/ready stream, or a free-running cycle counter.
- Sits at top level beside the CPU and replaces the bare RAM model used by the test harness.

Parameters:
- RAM_WORDS, 1024, data RAM depth in 32-bit words; power of 2.
- FIFO_DEPTH, 8, console FIFO entries; power of 2, at least 2.
- IO_BASE, 32'h8000_0000, base address of the I/O register window.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous active-high reset.
- memory_address  input  32  byte address from the CPU; bits [1:0] are ignored.
- memory_write  input  32  write data.
- memory_byte_enable  input  4  per-byte write enable; bit i selects memory_write[8i+7:8i].
- memory_we  input  1  write strobe.
- memory_read  output  32  read data, combinational from memory_address.
- cons_data  output  8  console byte at the FIFO head.
- cons_valid  output  1  FIFO not empty.
- cons_ready  input  1  sink accepts the head byte when cons_valid && cons_ready.
- bad_access  output  1  combinational; memory_we is high and the address is unmapped.

Behaviour:
- Address map (word = address[31:2]):
  - RAM: address < RAM_WORDS*4.
  - CONS_DATA at IO_BASE+0x0.
  - CONS_STATUS at IO_BASE+0x4.
  - CYCLE at IO_BASE+0x8.
  - CONS_COUNT at IO_BASE+0xC.
  - Everything else is unmapped.
- Reads: zero latency and combinational, matching the CPU's single-cycle memory stage.
  - Always a full 32-bit word; byte enables are ignored on reads.
  - Unmapped addresses and CONS_DATA read as 0.
- RAM writes:
  - On a clock edge with memory_we=1, only the enabled bytes of the addressed word are written.
  - memory_we=1 with byte_enable=0 is a no-op.
  - RAM is not cleared by rst; contents survive reset.
- CONS_DATA write (memory_we && byte_enable[0]): pushes memory_write[7:0].
  - If the FIFO is full and no pop happens that cycle, the byte is dropped and the sticky overflow flag is set.
  - Full with a simultaneous pop: the push is accepted and the count is unchanged.
- CONS_STATUS read value: {29'b0, overflow, full, empty}.
  - A write with byte_enable[0] && memory_write[2]=1 clears overflow.
  - If an overflowing push and a clear land in the same cycle, set wins.
  - All other bits are read-only.
- CONS_COUNT read value: zero-extended count, 0..FIFO_DEPTH. Writes are ignored.
- Console FIFO:
  - Circular buffer with read/write pointers plus a count register.
  - Pop on cons_valid && cons_ready.
  - No bypass: a byte pushed into an empty FIFO appears on cons_data/cons_valid the next cycle.
  - cons_data holds its value while cons_valid && !cons_ready.
  - Pointers wrap modulo FIFO_DEPTH.
  - cons_ready is ignored when empty.
- CYCLE counter:
  - Increments by 1 every cycle and wraps 0xFFFF_FFFF -> 0.
  - A write merges the enabled bytes into the current value. The counter takes the merged value next cycle and does not increment in that cycle.
- Reset values:
  - FIFO empty: count 0, pointers 0, cons_valid=0.
  - overflow=0, CYCLE=0.
  - cons_data, memory_read and bad_access follow their combinational definitions.
- Reset during a write: the write to FIFO/CYCLE/flags is discarded. A RAM write in the same cycle still commits; RAM has no reset.
- bad_access has no side effects; unmapped writes change no state.

Test Plan:
- RAM byte lanes: write 0xAABBCCDD to 0x10 with be=4'b1111, then 0x11223344 with be=4'b0101 -> read 0x10 returns 0xAA22CC44; a read of 0x12 returns the same word.
- FIFO stream: with cons_ready=0, write 0x41,0x42,0x43 to CONS_DATA -> CONS_COUNT=3, cons_data=0x41. Raise cons_ready for 3 cycles -> sink sees 0x41,0x42,0x43 in order, then cons_valid=0 and STATUS=0x1.
- Overflow: with cons_ready=0, write 9 bytes to CONS_DATA (FIFO_DEPTH=8) -> STATUS=0x6 and the 9th byte is dropped. A write of 0x4 to STATUS -> STATUS=0x2. A push while full with cons_ready=1 is accepted, overflow stays 0, count stays 8.
- Wrap-around: push/pop 20 bytes 0x00..0x13 with cons_ready alternating 1/0 -> output order exact, no loss, count never exceeds 8.
- CYCLE: after reset, reading CYCLE at cycle k returns k. Write 0xFFFF_FFFE with be=4'b1111 -> next-cycle reads are 0xFFFF_FFFE, then 0xFFFF_FFFF, then 0x0000_0000.
- Unmapped and reset: a write to 0x4000_0000 -> bad_access=1 for that cycle, a read there returns 0, RAM unchanged. Assert rst for 1 cycle while the FIFO holds 3 bytes and overflow=1 -> next cycle cons_valid=0, STATUS=0x1, CYCLE=0, earlier RAM data intact.
